config_loader: RTL

CONFIG_LOADER -- requirements
Module: config_loader

---
 rtl/config_loader_if.sv | 21 ++
 rtl/config_loader.sv | 102 ++++++++++
 2 files changed

// File: rtl/config_loader_if.sv
// Host word handshake between a configuration source and the loader.
// Ports: word_in (host->loader), word_valid (host->loader), word_ready (loader->host).
interface config_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output word_in,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_in,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/config_loader.sv
// Serialises host words MSB first into a CHAIN_LEN-bit configuration chain.
// Ports: clk, rst, start, abort, host (word handshake), cfg_data/cfg_en (chain), busy, done, bit_count.
module config_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 200,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    config_loader_if.slave   host,
    output logic             cfg_data,
    output logic             cfg_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_count
);

    localparam int WC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WC_W-1:0]  LAST_WB  = WC_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] sh;
    logic [WC_W-1:0]   wcnt;

    // The chain only ever sees data while shifting.
    assign cfg_data = cfg_en & sh[WORD_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            sh              <= '0;
            wcnt            <= '0;
            bit_count       <= '0;
            host.word_ready <= 1'b0;
            cfg_en          <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && state != ST_IDLE) begin
                // Abort wins over everything; bit_count is left as-is.
                state           <= ST_IDLE;
                host.word_ready <= 1'b0;
                cfg_en          <= 1'b0;
                busy            <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            bit_count       <= '0;
                            state           <= ST_LOAD;
                            host.word_ready <= 1'b1;
                            busy            <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        if (host.word_valid) begin
                            sh              <= host.word_in;
                            wcnt            <= '0;
                            state           <= ST_SHIFT;
                            host.word_ready <= 1'b0;
                            cfg_en          <= 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        sh        <= sh << 1;
                        wcnt      <= wcnt + WC_W'(1);
                        bit_count <= bit_count + CNT_W'(1);
                        if (bit_count == LAST_BIT) begin
                            // Chain full: drop any bits left in the word.
                            state  <= ST_DONE;
                            cfg_en <= 1'b0;
                            done   <= 1'b1;
                        end else if (wcnt == LAST_WB) begin
                            state           <= ST_LOAD;
                            cfg_en          <= 1'b0;
                            host.word_ready <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
